// File: rtl/in_sync_tx_pkg.sv
// Shared decoder package: FSM state encoding and Gray/binary pointer conversion helpers.
package in_sync_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PPS   = 2'd1,
        SLICE = 2'd2
    } state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/in_sync_tx_if.sv
// Source handshake plus FIFO write-side bus of in_sync_tx; slave = framer, master = source/FIFO side.
interface in_sync_tx_if #(
    parameter int DATA_WIDTH = 256
) ();
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic                  src_last;
    logic                  src_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_sof;
    logic                  out_data_is_pps;

    modport slave (
        input  src_data, src_valid, src_last,
        output src_ready, out_data, out_valid, out_sof, out_data_is_pps
    );

    modport master (
        output src_data, src_valid, src_last,
        input  src_ready, out_data, out_valid, out_sof, out_data_is_pps
    );
endinterface

// File: rtl/in_sync_tx_sync.sv
// Two-flop single-bit synchronizer with async reset and a synchronous clear.
module in_sync_tx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else if (clr_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/in_sync_tx.sv
// in_sync_tx: frames PPS and slice words into the write port of the clock-crossing FIFO.
// Optional word/stall statistics counters are built when IN_SYNC_TX_STATS_EN is defined.
module in_sync_tx
    import in_sync_tx_pkg::*;
#(
    parameter int NUMBER_OF_LINES = 4,
    parameter int DATA_WIDTH      = 256,
    parameter int PPS_WORDS       = 4,
    localparam int ADDR_WIDTH     = $clog2(NUMBER_OF_LINES) + 1
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] rd_ptr_gray,
    in_sync_tx_if.slave           bus,
    output logic                  frame_err
`ifdef IN_SYNC_TX_STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int PCW = (PPS_WORDS > 1) ? $clog2(PPS_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(2 * NUMBER_OF_LINES - 1);
    localparam logic [ADDR_WIDTH:0]   PTR_SPAN  = (ADDR_WIDTH + 1)'(2 * NUMBER_OF_LINES);
    localparam logic [ADDR_WIDTH:0]   OCC_LIMIT = (ADDR_WIDTH + 1)'(NUMBER_OF_LINES);
    localparam logic [PCW-1:0]        PPS_LAST  = PCW'(PPS_WORDS - 1);

    state_e                  state_q;
    logic                    sof_pending_q;
    logic [PCW-1:0]          pps_cnt_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr_d;
    logic                    out_valid_q;
    logic                    out_sof_q;
    logic                    out_pps_q;
    logic                    frame_err_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    logic [ADDR_WIDTH-1:0]   rd_gray_sync;
    logic [ADDR_WIDTH-1:0]   rd_ptr_sync;
    logic [ADDR_WIDTH:0]     occupancy;
    logic                    src_ready;
    logic                    xfer;

    for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rd_sync
        in_sync_tx_sync u_sync (
            .clk_i  (clk_wr),
            .rst_ni (rst_n),
            .clr_i  (flush),
            .d_i    (rd_ptr_gray[i]),
            .q_o    (rd_gray_sync[i])
        );
    end

    assign rd_ptr_sync = ADDR_WIDTH'(gray2bin(32'(rd_gray_sync)));

    // One extra bit keeps the modular subtraction exact when the ring is not a power of two.
    always_comb begin
        occupancy = {1'b0, wr_ptr_q} - {1'b0, rd_ptr_sync};
        if (wr_ptr_q < rd_ptr_sync) begin
            occupancy = occupancy + PTR_SPAN;
        end
    end

    assign src_ready = (occupancy < OCC_LIMIT) & ~flush & (state_q != IDLE) & ~frame_err_q;
    assign xfer      = bus.src_valid & src_ready;
    assign wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sof_pending_q <= 1'b0;
            pps_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_pps_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else if (flush) begin
            state_q       <= IDLE;
            sof_pending_q <= 1'b0;
            pps_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_pps_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            out_valid_q <= xfer;
            out_sof_q   <= xfer & sof_pending_q;
            out_pps_q   <= xfer & (state_q == PPS);
            if (xfer) begin
                wr_ptr_q      <= wr_ptr_d;
                sof_pending_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q       <= PPS;
                        sof_pending_q <= 1'b1;
                        pps_cnt_q     <= '0;
                    end
                end
                PPS: begin
                    if (xfer) begin
                        pps_cnt_q <= pps_cnt_q + PCW'(1);
                        // A frame that ends inside its parameter set is malformed.
                        if (bus.src_last) begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end else if (pps_cnt_q == PPS_LAST) begin
                            state_q <= SLICE;
                        end
                    end
                end
                SLICE: begin
                    if (xfer && bus.src_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_wr) begin
        if (xfer) begin
            out_data_q <= bus.src_data;
        end
    end

    assign bus.src_ready       = src_ready;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_sof         = out_sof_q;
    assign bus.out_data_is_pps = out_pps_q;
    assign frame_err           = frame_err_q;

`ifdef IN_SYNC_TX_STATS_EN
    logic [31:0] word_cnt_q;
    logic [31:0] stall_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (flush) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer) begin
                word_cnt_q <= sat_inc(word_cnt_q);
            end
            if (bus.src_valid && !src_ready && (state_q != IDLE)) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_in_sync_tx.sv
// Testbench for in_sync_tx; statistics scenario included when IN_SYNC_TX_STATS_EN is defined.
module tb_in_sync_tx;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int PW   = 4;
    localparam int AW   = 3;
    localparam int RING = 8;

    logic          clk_wr = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          frame_start;
    logic [AW-1:0] rd_ptr_gray;
    logic          frame_err;
`ifdef IN_SYNC_TX_STATS_EN
    logic [31:0]   word_cnt;
    logic [31:0]   stall_cnt;
`endif

    in_sync_tx_if #(.DATA_WIDTH(DW)) bif ();

    in_sync_tx #(
        .NUMBER_OF_LINES (N),
        .DATA_WIDTH      (DW),
        .PPS_WORDS       (PW)
    ) dut (
        .clk_wr      (clk_wr),
        .rst_n       (rst_n),
        .flush       (flush),
        .frame_start (frame_start),
        .rd_ptr_gray (rd_ptr_gray),
        .bus         (bif),
        .frame_err   (frame_err)
`ifdef IN_SYNC_TX_STATS_EN
        ,
        .word_cnt    (word_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk_wr = ~clk_wr;

    // Reference model: frame phase by word index, FIFO fill by write count vs. delayed read pointer.
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_cur  = 0;
    bit          rd_follow = 1'b0;
    logic        m_active, m_err;
    int          m_idx, m_wr, rs1, rs2, m_words, m_stalls;
    logic        e_valid, e_sof, e_pps;
    logic [DW-1:0] e_data;
    logic        x_rdy, o_rdy, last_xfer;

    assign rd_ptr_gray = AW'(rd_cur ^ (rd_cur >> 1));

    function automatic int occ(input int w, input int r);
        return (w - r + RING) % RING;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_active = 1'b0; m_err = 1'b0; m_idx = 0; m_wr = 0; rs1 = 0; rs2 = 0;
        m_words = 0; m_stalls = 0;
        e_valid = 1'b0; e_sof = 1'b0; e_pps = 1'b0;
    endtask

    task automatic tick();
        logic f;
        logic xfer;
        #1;
        f     = flush;
        x_rdy = m_active && !m_err && !f && (occ(m_wr, rs2) < N);
        o_rdy = bif.src_ready;
        @(posedge clk_wr);
        xfer = 1'b0;
        if (f) begin
            model_clear();
        end else begin
            xfer = bif.src_valid && x_rdy;
            if (m_active && bif.src_valid && !x_rdy) m_stalls++;
            e_valid = xfer;
            e_sof   = xfer && (m_idx == 0);
            e_pps   = xfer && (m_idx < PW);
            if (xfer) begin
                e_data = bif.src_data;
                m_wr   = (m_wr + 1) % RING;
                m_words++;
                if (bif.src_last) begin
                    if (m_idx < PW) m_err = 1'b1;
                    m_active = 1'b0;
                end
                m_idx++;
            end else if (!m_active && frame_start) begin
                m_active = 1'b1;
                m_idx    = 0;
            end
            rs2 = rs1;
            rs1 = rd_cur;
        end
        last_xfer = xfer;
        #1;
        if (rd_follow) rd_cur = m_wr;
    endtask

    task automatic clean();
        flush = 1'b1; frame_start = 1'b0; bif.src_valid = 1'b0; bif.src_last = 1'b0;
        rd_cur = 0; rd_follow = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; frame_start = 1'b0; rd_cur = 0; rd_follow = 1'b0;
        bif.src_valid = 1'b0; bif.src_last = 1'b0; bif.src_data = '0;
        model_clear();
        repeat (3) @(posedge clk_wr);
        #1;
        n_tests++;
        if ({bif.src_ready, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state got %b exp 00000",
                     {bif.src_ready, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err});
        end
        rst_n = 1'b1; frame_start = 1'b1; bif.src_valid = 1'b1; bif.src_data = rnd();
        for (int i = 0; i < 2; i++) begin
            tick();
            frame_start = 1'b0;
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL reset_release rdy/vld/sof/pps/err got %b exp %b",
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bif.src_ready, bif.out_valid, bif.out_sof, bif.out_data_is_pps} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp 0000",
                     {bif.src_ready, bif.out_valid, bif.out_sof, bif.out_data_is_pps});
        end
        model_clear();
        @(posedge clk_wr);
        #1;
        rst_n = 1'b1; bif.src_valid = 1'b0;
    endtask

    task automatic test_frame();
        int k = 0, cyc = 0, nv = 0;
        logic [6:0] sofs = '0, ppss = '0;
        logic [DW-1:0] cur = rnd();
        clean();
        rd_follow = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        while (k < 7 && cyc < 40) begin
            bif.src_valid = 1'b1; bif.src_last = (k == 6); bif.src_data = cur;
            tick(); cyc++;
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL frame_ctl rdy/vld/sof/pps/err got %b exp %b",
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
            if (e_valid) begin
                n_tests++;
                if (bif.out_data !== e_data) begin
                    n_fail++;
                    $display("FAIL frame_data got %h exp %h", bif.out_data, e_data);
                end
            end
            if (bif.out_valid && nv < 7) begin
                sofs[nv] = bif.out_sof; ppss[nv] = bif.out_data_is_pps; nv++;
            end
            if (last_xfer) begin k++; cur = rnd(); end
        end
        bif.src_last = 1'b0;
        tick();
        bif.src_valid = 1'b0;
        n_tests++;
        if (nv != 7 || sofs !== 7'b0000001 || ppss !== 7'b0001111 || o_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_flags words=%0d sof=%b pps=%b rdy_after=%b exp 7 0000001 0001111 0",
                     nv, sofs, ppss, o_rdy);
        end
    endtask

    task automatic test_backpressure();
        int nv = 0;
        clean();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) rd_cur = 3;
            bif.src_valid = 1'b1; bif.src_last = 1'b0; bif.src_data = rnd();
            tick();
            if (i < 12) nv += int'(bif.out_valid);
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL backpressure_ctl cyc %0d got %b exp %b", i,
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
            if (i == 11) begin
                n_tests++;
                if (nv != 4 || o_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_count got %0d rdy %b exp 4 rdy 0", nv, o_rdy);
                end
            end
        end
        bif.src_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] got[$];
        int k = 0, cyc = 0, bad = 0;
        logic [DW-1:0] cur = rnd();
        clean();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        while ((k < 20 || cyc < 60) && cyc < 600) begin
            bif.src_valid = (k < 20) && ($urandom_range(0, 3) != 0);
            bif.src_last = (k == 19); bif.src_data = cur;
            tick(); cyc++;
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL wrap_ctl cyc %0d got %b exp %b", cyc,
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
            if (last_xfer) begin sent.push_back(cur); k++; cur = rnd(); end
            if (bif.out_valid) got.push_back(bif.out_data);
            if (occ(m_wr, rd_cur) > 0 && $urandom_range(0, 2) != 0) rd_cur = (rd_cur + 1) % RING;
        end
        bif.src_valid = 1'b0;
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            if (got[i] !== sent[i]) bad++;
        end
        n_tests++;
        if (got.size() != 20 || sent.size() != 20 || bad != 0) begin
            n_fail++;
            $display("FAIL wrap_words got %0d sent %0d out_of_order %0d exp 20 20 0",
                     got.size(), sent.size(), bad);
        end
    endtask

    task automatic test_pps_error();
        int k = 0, cyc = 0;
        clean();
        rd_follow = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        while (k < 3 && cyc < 30) begin
            bif.src_valid = 1'b1; bif.src_last = (k == 2); bif.src_data = rnd();
            tick(); cyc++;
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL pps_err_ctl got %b exp %b",
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
            if (last_xfer) k++;
        end
        bif.src_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame_start = (i == 1);
            tick();
            n_tests++;
            if (o_rdy !== 1'b0 || frame_err !== 1'b1 || bif.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pps_err_hold rdy %b err %b vld %b exp 0 1 0", o_rdy, frame_err, bif.out_valid);
            end
        end
        frame_start = 1'b0; flush = 1'b1; bif.src_valid = 1'b0;
        tick();
        flush = 1'b0; bif.src_valid = 1'b1;
        tick();
        bif.src_valid = 1'b0;
        n_tests++;
        if (frame_err !== 1'b0 || o_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL pps_err_flush err %b rdy %b exp 0 0", frame_err, o_rdy);
        end
    endtask

    task automatic test_flush();
        int k = 0, cyc = 0, nv = 0;
        clean();
        rd_follow = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        while (k < 6 && cyc < 40) begin
            bif.src_valid = 1'b1; bif.src_last = 1'b0; bif.src_data = rnd();
            tick(); cyc++;
            if (last_xfer) k++;
        end
        rd_follow = 1'b0; rd_cur = 0;
        flush = 1'b1; bif.src_valid = 1'b1; bif.src_data = rnd();
        tick();
        flush = 1'b0;
        n_tests++;
        if (bif.out_valid !== 1'b0 || o_rdy !== 1'b0 || e_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_valid vld %b rdy %b exp 0 0", bif.out_valid, o_rdy);
        end
        tick();
        n_tests++;
        if (o_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle rdy %b exp 0", o_rdy);
        end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bif.src_valid = 1'b1; bif.src_data = rnd();
            tick();
            nv += int'(bif.out_valid);
            n_tests++;
            if ({o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err} !==
                {x_rdy, e_valid, e_sof, e_pps, m_err}) begin
                n_fail++;
                $display("FAIL flush_restart_ctl got %b exp %b",
                         {o_rdy, bif.out_valid, bif.out_sof, bif.out_data_is_pps, frame_err},
                         {x_rdy, e_valid, e_sof, e_pps, m_err});
            end
        end
        bif.src_valid = 1'b0;
        n_tests++;
        if (nv != 4) begin
            n_fail++;
            $display("FAIL flush_wrptr transfers %0d exp 4", nv);
        end
    endtask

`ifdef IN_SYNC_TX_STATS_EN
    task automatic test_stats();
        int sent = 0, cyc = 0;
        clean();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        while (sent < 4 && cyc < 20) begin
            bif.src_valid = 1'b1; bif.src_last = 1'b0; bif.src_data = rnd();
            tick(); cyc++;
            if (last_xfer) sent++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (o_rdy !== x_rdy) begin
                n_fail++;
                $display("FAIL stats_stall_rdy got %b exp %b", o_rdy, x_rdy);
            end
        end
        bif.src_valid = 1'b0; rd_cur = 4;
        repeat (3) tick();
        rd_follow = 1'b1; cyc = 0;
        while (sent < 10 && cyc < 40) begin
            bif.src_valid = 1'b1; bif.src_last = (sent == 9); bif.src_data = rnd();
            tick(); cyc++;
            if (last_xfer) sent++;
        end
        bif.src_valid = 1'b0; bif.src_last = 1'b0;
        tick();
        n_tests++;
        if (word_cnt !== 32'd10 || stall_cnt !== 32'd3 || m_words != 10 || m_stalls != 3) begin
            n_fail++;
            $display("FAIL stats_counts word %0d stall %0d exp 10 3", word_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_wrap();
        test_pps_error();
        test_flush();
`ifdef IN_SYNC_TX_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/in_sync_tx.md
IN_SYNC_TX -- requirements
Module: in_sync_tx

Interface
REQ-001 SHALL have parameter NUMBER_OF_LINES, default 4, the depth of the downstream clock-crossing FIFO whose write port this block drives.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, the bitstream word width.
REQ-003 SHALL have parameter PPS_WORDS, default 4, the number of words in a picture parameter set (128 bytes at 256 bits).
REQ-004 SHALL have derived constant ADDR_WIDTH = clog2(NUMBER_OF_LINES)+1.
REQ-005 SHALL have port clk_wr, input, 1 bit, the write-domain clock.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit, synchronous clear shared with the downstream FIFO.
REQ-008 SHALL have port frame_start, input, 1 bit, a pulse that arms a new frame.
REQ-009 SHALL have port src_data, input, DATA_WIDTH bits, the source word.
REQ-010 SHALL have port src_valid, input, 1 bit, source word valid.
REQ-011 SHALL have port src_last, input, 1 bit, marking the last word of the frame.
REQ-012 SHALL have port src_ready, output, 1 bit, source accept.
REQ-013 SHALL have port rd_ptr_gray, input, ADDR_WIDTH bits, the downstream read pointer in Gray code, asynchronous to clk_wr.
REQ-014 SHALL have outputs out_data (DATA_WIDTH), out_valid (1), out_sof (1) and out_data_is_pps (1), all registered, as the FIFO write side.
REQ-015 SHALL have output frame_err, 1 bit, a sticky protocol error flag.

Function
REQ-016 SHALL transfer a word when src_valid & src_ready.
REQ-017 SHALL present each transferred word on out_* at the next clk_wr edge, giving exactly 1-cycle latency, with out_valid high for 1 cycle per word.
REQ-018 SHALL hold out_valid, out_sof and out_data_is_pps at 0 when no transfer occurs; out_data SHALL hold its previous value.
REQ-019 SHALL synchronize rd_ptr_gray bit-wise through 2 flops and then convert it to binary as rd_ptr_sync.
REQ-020 SHALL keep wr_ptr at ADDR_WIDTH bits, incrementing it per transfer and wrapping from 2*NUMBER_OF_LINES-1 to 0.
REQ-021 SHALL compute occupancy = (wr_ptr - rd_ptr_sync) mod 2*NUMBER_OF_LINES.
REQ-022 SHALL compute src_ready = (occupancy < NUMBER_OF_LINES) & ~flush & (state != IDLE) & ~frame_err, combinationally.
REQ-023 SHALL implement FSM states IDLE, PPS and SLICE.
REQ-024 SHALL transition IDLE->PPS on frame_start, setting sof_pending=1 and pps_cnt=0.
REQ-025 SHALL, in PPS, drive out_data_is_pps=1 on each transfer and increment pps_cnt; the transfer with pps_cnt==PPS_WORDS-1 SHALL move the FSM to SLICE.
REQ-026 SHALL, in SLICE, drive out_data_is_pps=0; a transfer with src_last=1 SHALL move the FSM to IDLE.
REQ-027 SHALL drive out_sof=1 only on the first transfer after frame_start, which clears sof_pending.
REQ-028 SHALL, when src_last=1 on a PPS-state transfer, forward the word, set frame_err, and move the FSM to IDLE.
REQ-029 SHALL ignore frame_start outside IDLE.
REQ-030 SHALL give flush priority over frame_start and over a transfer in the same cycle.

Reset
REQ-031 SHALL, on rst_n low, set out_valid, out_sof, out_data_is_pps, frame_err, wr_ptr, pps_cnt and the synchronizer flops to 0 and the FSM to IDLE; out_data SHALL be unreset.
REQ-032 SHALL, on flush, apply the same values as reset in 1 cycle and abort any frame in progress mid-operation.
REQ-033 SHALL leave src_ready low during flush and in the cycle of reset release.

Configuration
REQ-034 SHALL, with IN_SYNC_TX_STATS_EN defined, add outputs word_cnt[31:0] (transfers since reset or flush) and stall_cnt[31:0] (cycles with src_valid & ~src_ready in PPS or SLICE), both saturating at all-ones.
REQ-035 SHALL, without IN_SYNC_TX_STATS_EN, omit those ports and their logic.

Structure
REQ-036 SHALL place the FSM state enum and the bin2gray/gray2bin functions in the shared decoder package.
REQ-037 SHALL instantiate the existing 1-bit synchronizer sub-module once per rd_ptr_gray bit.

Verification
REQ-038 SHALL verify: frame_start, 4 PPS words, then 3 slice words with the last one flagged -> out_sof on word 0 only, out_data_is_pps on words 0-3, FSM back in IDLE.
REQ-039 SHALL verify: rd_ptr_gray held at 0, source continuously valid -> exactly 4 transfers, then src_ready=0 until rd_ptr advances.
REQ-040 SHALL verify: rd_ptr stepping 0..7 and wrapping while wr_ptr wraps 7->0 -> no lost or extra words over 20 words.
REQ-041 SHALL verify: src_last on PPS word 2 -> frame_err=1, FSM in IDLE, src_ready=0 until flush.
REQ-042 SHALL verify: flush asserted mid-SLICE together with a transfer -> no out_valid next cycle, wr_ptr=0, state IDLE.
REQ-043 SHALL verify: with IN_SYNC_TX_STATS_EN, 10 words plus 3 stall cycles -> word_cnt=10, stall_cnt=3.
